// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------
// bus_arbiter_if : request / bus-in-use / grant lines of the bus
// Rev 1.0
// ---------------------------------------------------------------
interface bus_arbiter_if #(
    parameter int NUM_MASTERS = 3
) ();
    logic [NUM_MASTERS-1:0] b_request;
    logic                   b_bus_utilizing;
    logic [NUM_MASTERS-1:0] b_grant;

    modport master (
        output b_request,
        output b_bus_utilizing,
        input  b_grant
    );

    modport slave (
        input  b_request,
        input  b_bus_utilizing,
        output b_grant
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------
// bus_arbiter : round-robin bus arbiter with grant-idle timeout
// Rev 1.0
// ---------------------------------------------------------------
module bus_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ID_WIDTH    = 2,
    parameter int TIMEOUT_LEN = 6
) (
    input  wire logic                clk,
    input  wire logic                rstn,
    bus_arbiter_if.slave             bus,
    output logic [ID_WIDTH-1:0]      owner_id,
    output logic                     arb_busy,
    output logic                     timeout_err
);

    localparam logic [ID_WIDTH-1:0]    c_last = ID_WIDTH'(NUM_MASTERS - 1);
    localparam logic [TIMEOUT_LEN-1:0] c_tmax = '1;
    localparam logic [NUM_MASTERS-1:0] c_one  = NUM_MASTERS'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] req_s_q;
    logic                   util_s_q;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [ID_WIDTH-1:0]    owner_q, owner_d;
    logic [ID_WIDTH-1:0]    ptr_q, ptr_d;
    logic [TIMEOUT_LEN-1:0] timer_q, timer_d;
    logic                   busy_q, busy_d;
    logic                   tout_q, tout_d;

    logic [ID_WIDTH-1:0]    cand;
    logic [ID_WIDTH-1:0]    win_idx;
    logic                   win_found;
    logic                   owner_req;

    // Round-robin search starting just after the last owner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = ptr_q;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = (cand == c_last) ? '0 : cand + 1'b1;
            if (!win_found && req_s_q[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign owner_req = req_s_q[owner_q];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        timer_d = timer_q;
        tout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found && !util_s_q) begin
                    state_d = ST_GRANT;
                    grant_d = c_one << win_idx;
                    owner_d = win_idx;
                    timer_d = '0;
                end
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                end else if (util_s_q) begin
                    state_d = ST_BUSY;
                    timer_d = '0;
                end else if (timer_q == c_tmax) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                    tout_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_BUSY: begin
                if (!owner_req) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                end
            end
            ST_RELEASE: begin
                grant_d = '0;
                if (!util_s_q) begin
                    state_d = ST_IDLE;
                    ptr_d   = owner_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Bus lines are sampled once before the FSM acts on them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            req_s_q  <= '0;
            util_s_q <= 1'b0;
            grant_q  <= '0;
            owner_q  <= '0;
            ptr_q    <= c_last;
            timer_q  <= '0;
            busy_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_s_q  <= bus.b_request;
            util_s_q <= bus.b_bus_utilizing;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            timer_q  <= timer_d;
            busy_q   <= busy_d;
            tout_q   <= tout_d;
        end
    end

    assign bus.b_grant  = grant_q;
    assign owner_id     = owner_q;
    assign arb_busy     = busy_q;
    assign timeout_err  = tout_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_bus_arbiter : directed bench with a reference model of the arbiter
// Rev 1.0
// ---------------------------------------------------------------
module tb_bus_arbiter;
    localparam int N    = 3;
    localparam int TL   = 6;
    localparam int TMAX = (1 << TL) - 1;

    logic       clk;
    logic       rstn;
    logic [1:0] owner_id;
    logic       arb_busy;
    logic       timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

    bus_arbiter #(
        .NUM_MASTERS(N),
        .ID_WIDTH   (2),
        .TIMEOUT_LEN(TL)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus.slave),
        .owner_id   (owner_id),
        .arb_busy   (arb_busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input int p, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (((r >> ((p + k) % N)) & 3'd1) != 3'd0) return (p + k) % N;
        end
        return 0;
    endfunction

    // Reference model: inputs are seen one edge after being driven.
    logic [N-1:0] m_req;
    logic         m_util;
    int           m_ptr;
    bit           m_own, m_onbus, m_drain;
    int           m_age;
    logic [N-1:0] e_grant;
    int           e_owner;
    bit           e_busy, e_tout;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_req   <= '0;
            m_util  <= 1'b0;
            m_ptr   <= N - 1;
            m_own   <= 1'b0;
            m_onbus <= 1'b0;
            m_drain <= 1'b0;
            m_age   <= 0;
            e_grant <= '0;
            e_owner <= 0;
            e_busy  <= 1'b0;
            e_tout  <= 1'b0;
        end else begin
            m_req  <= bus.b_request;
            m_util <= bus.b_bus_utilizing;
            e_tout <= 1'b0;
            if (m_own) begin
                if (((m_req >> e_owner) & 3'd1) == 3'd0) begin
                    m_own <= 1'b0; m_drain <= 1'b1; e_grant <= '0;
                end else if (!m_onbus && m_util) begin
                    m_onbus <= 1'b1;
                end else if (!m_onbus && m_age == TMAX) begin
                    e_tout <= 1'b1; m_own <= 1'b0; m_drain <= 1'b1; e_grant <= '0;
                end else if (!m_onbus) begin
                    m_age <= m_age + 1;
                end
            end else if (m_drain) begin
                if (!m_util) begin
                    m_drain <= 1'b0; m_ptr <= e_owner; e_busy <= 1'b0;
                end
            end else if (m_req != '0 && !m_util) begin
                m_own   <= 1'b1;
                m_onbus <= 1'b0;
                m_age   <= 0;
                e_owner <= pick(m_ptr, m_req);
                e_grant <= 3'b001 << pick(m_ptr, m_req);
                e_busy  <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            check("cmp_grant", 32'(bus.b_grant), 32'(e_grant));
            check("cmp_owner", 32'(owner_id), 32'(e_owner));
            check("cmp_busy", 32'(arb_busy), 32'(e_busy));
            check("cmp_tout", 32'(timeout_err), 32'(e_tout));
            check("cmp_onehot", 32'($onehot0(bus.b_grant)), 32'd1);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.b_request = '0;
        bus.b_bus_utilizing = 1'b0;
        tick(); tick();
        rstn = 1'b1;
    endtask

    task automatic wait_grant(input string name, input logic [N-1:0] exp, input int max,
                              output int zeros);
        int n;
        n = 0;
        zeros = 0;
        while (bus.b_grant !== exp && n < max) begin
            tick();
            n++;
            if (bus.b_grant == '0) zeros++;
        end
        check(name, 32'(bus.b_grant), 32'(exp));
    endtask

    initial begin
        int z;
        int cnt;
        logic [N-1:0] order [4];
        order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;

        rstn = 1'b0;
        bus.b_request = '0;
        bus.b_bus_utilizing = 1'b0;
        tick(); tick();
        check("rst_grant", 32'(bus.b_grant), 32'd0);
        check("rst_owner", 32'(owner_id), 32'd0);
        check("rst_busy", 32'(arb_busy), 32'd0);
        check("rst_tout", 32'(timeout_err), 32'd0);
        rstn = 1'b1;

        // 1: single request, latency and release
        bus.b_request = 3'b001;
        tick();
        check("t1_lat", 32'(bus.b_grant), 32'd0);
        tick();
        check("t1_grant", 32'(bus.b_grant), 32'b001);
        check("t1_owner", 32'(owner_id), 32'd0);
        check("t1_busy", 32'(arb_busy), 32'd1);
        bus.b_bus_utilizing = 1'b1;
        tick(); tick();
        bus.b_request = 3'b000;
        tick(); tick();
        check("t1_rel_grant", 32'(bus.b_grant), 32'd0);
        check("t1_rel_busy", 32'(arb_busy), 32'd1);
        bus.b_bus_utilizing = 1'b0;
        cnt = 0;
        while (arb_busy && cnt < 10) begin tick(); cnt++; end
        check("t1_idle", 32'(arb_busy), 32'd0);

        // 2: round-robin order with all masters requesting
        do_reset();
        bus.b_request = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_grant("t2_order", order[i], 12, z);
            if (i > 0) check("t2_gap", 32'(z >= 1), 32'd1);
            bus.b_bus_utilizing = 1'b1;
            tick(); tick();
            bus.b_request = 3'b111 & ~bus.b_grant;
            bus.b_bus_utilizing = 1'b0;
            wait_grant("t2_drop", 3'b000, 8, z);
            bus.b_request = 3'b111;
        end
        bus.b_request = 3'b000;
        wait_grant("t2_end", 3'b000, 8, z);

        // 3: other requests ignored during a BUSY tenure
        do_reset();
        bus.b_request = 3'b010;
        wait_grant("t3_grant", 3'b010, 8, z);
        bus.b_bus_utilizing = 1'b1;
        tick(); tick(); tick();
        bus.b_request = 3'b110;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_hold", 32'(bus.b_grant), 32'b010);
        end
        bus.b_request = 3'b100;
        bus.b_bus_utilizing = 1'b0;
        wait_grant("t3_next", 3'b100, 12, z);
        bus.b_request = 3'b000;
        wait_grant("t3_end", 3'b000, 8, z);

        // 4: timeout of an idle grant
        do_reset();
        bus.b_request = 3'b001;
        wait_grant("t4_grant", 3'b001, 8, z);
        bus.b_request = 3'b011;
        cnt = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (timeout_err) break;
            if (bus.b_grant == 3'b001) cnt++;
        end
        check("t4_tout", 32'(timeout_err), 32'd1);
        check("t4_tout_grant", 32'(bus.b_grant), 32'd0);
        check("t4_len", 32'(cnt), 32'd64);
        tick();
        check("t4_pulse", 32'(timeout_err), 32'd0);
        wait_grant("t4_next", 3'b010, 10, z);
        bus.b_request = 3'b000;
        wait_grant("t4_end", 3'b000, 8, z);

        // 5: no grant while the bus line is held
        do_reset();
        bus.b_bus_utilizing = 1'b1;
        bus.b_request = 3'b101;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t5_nogrant", 32'(bus.b_grant), 32'd0);
        end
        bus.b_bus_utilizing = 1'b0;
        tick();
        check("t5_wait", 32'(bus.b_grant), 32'd0);
        tick();
        check("t5_grant", 32'(bus.b_grant), 32'b001);
        bus.b_request = 3'b000;
        wait_grant("t5_end", 3'b000, 8, z);

        // 6: asynchronous reset during BUSY
        bus.b_request = 3'b010;
        wait_grant("t6_grant", 3'b010, 12, z);
        bus.b_bus_utilizing = 1'b1;
        tick(); tick(); tick();
        #2;
        rstn = 1'b0;
        #1;
        check("t6_rst_grant", 32'(bus.b_grant), 32'd0);
        check("t6_rst_busy", 32'(arb_busy), 32'd0);
        check("t6_rst_owner", 32'(owner_id), 32'd0);
        bus.b_request = 3'b011;
        bus.b_bus_utilizing = 1'b0;
        tick();
        rstn = 1'b1;
        wait_grant("t6_prio", 3'b001, 10, z);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
